// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - shared types and idle levels for the SD-card SPI master
package sd_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MOSI_IDLE = 1'b1;

endpackage

// File: rtl/sd_spi_sync_fifo.sv
// rtl/sd_spi_sync_fifo.sv - show-ahead synchronous FIFO used for the TX and RX byte queues
module sd_spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB separates the full and empty cases when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sd_spi_master_fifo.sv
// rtl/sd_spi_master_fifo.sv - buffered SPI master for the SD-card port
// TX bytes are shifted out MSB first; captured MISO frames land in the RX FIFO.
module sd_spi_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8,
  parameter int NUM_CS     = 1,
  parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iWrite,
  input  logic [DATA_W-1:0] iWriteData,
  output logic              oTxFull,
  input  logic              iRead,
  output logic [DATA_W-1:0] oReadData,
  output logic              oRxEmpty,
  input  logic [DIV_W-1:0]  iDivider,
  input  logic [CS_W-1:0]   iCsSel,
  input  logic              iCsAssert,
  output logic              oBusy,
  output logic              SD_CLK,
  output logic              SD_MOSI,
  input  logic              SD_MISO,
  output logic [NUM_CS-1:0] SD_CS
);

  import sd_spi_pkg::*;

  localparam int EW = $clog2(2*DATA_W);

  state_t              state;
  state_t              next_state;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    hcnt;
  logic [EW-1:0]       ecnt;
  logic [DATA_W-1:0]   sr;
  logic                cap;
  logic                sclk_q;
  logic                mosi_q;
  logic [NUM_CS-1:0]   cs_q;
  logic [NUM_CS-1:0]   cs_next;
  logic [DATA_W-1:0]   tx_dout;
  logic                tx_empty;
  logic                rx_full;
  logic                tx_pop;
  logic                rx_push;
  logic                load;
  logic                shifting;
  logic                can_start;
  logic                edge_hit;
  logic                last_edge;
  logic                lead;

  sd_spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .push  (iWrite),
    .din   (iWriteData),
    .pop   (tx_pop),
    .dout  (tx_dout),
    .full  (oTxFull),
    .empty (tx_empty)
  );

  sd_spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .push  (rx_push),
    .din   (sr),
    .pop   (iRead),
    .dout  (oReadData),
    .full  (rx_full),
    .empty (oRxEmpty)
  );

  assign can_start = !tx_empty && !rx_full;
  assign edge_hit  = (state == SHIFT) && (hcnt == div_q);
  assign last_edge = edge_hit && (ecnt == EW'(2*DATA_W-1));
  assign lead      = !ecnt[0];

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= next_state;
  end

  // A frame that finishes with RX still full waits in DONE rather than dropping data.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (can_start) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (last_edge) next_state = DONE;
      DONE: begin
        if (rx_full)        next_state = DONE;
        else if (!tx_empty) next_state = LOAD;
        else                next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    load     = 1'b0;
    shifting = 1'b0;
    case (state)
      LOAD:  begin tx_pop = 1'b1; load = 1'b1; end
      SHIFT: shifting = 1'b1;
      DONE:  rx_push = !rx_full;
      default: ;
    endcase
  end

  always_comb begin
    cs_next = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (iCsAssert && (int'(iCsSel) == i)) cs_next[i] = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      div_q  <= '0;
      hcnt   <= '0;
      ecnt   <= '0;
      sr     <= '0;
      cap    <= 1'b0;
      sclk_q <= CPOL;
      mosi_q <= MOSI_IDLE;
      cs_q   <= '1;
    end else begin
      if (state == IDLE) cs_q <= cs_next;
      if (load) begin
        sr     <= tx_dout;
        div_q  <= iDivider;
        hcnt   <= '0;
        ecnt   <= '0;
        mosi_q <= (CPHA == 1'b0) ? tx_dout[DATA_W-1] : MOSI_IDLE;
      end
      if (shifting) begin
        if (edge_hit) begin
          hcnt   <= '0;
          ecnt   <= ecnt + EW'(1);
          sclk_q <= !sclk_q;
          if (lead) begin
            if (CPHA == 1'b0) cap    <= SD_MISO;
            else              mosi_q <= sr[DATA_W-1];
          end else if (CPHA == 1'b0) begin
            sr     <= {sr[DATA_W-2:0], cap};
            mosi_q <= last_edge ? MOSI_IDLE : sr[DATA_W-2];
          end else begin
            sr <= {sr[DATA_W-2:0], SD_MISO};
            if (last_edge) mosi_q <= MOSI_IDLE;
          end
        end else begin
          hcnt <= hcnt + DIV_W'(1);
        end
      end
    end
  end

  assign SD_CLK  = sclk_q;
  assign SD_MOSI = mosi_q;
  assign SD_CS   = cs_q;
  assign oBusy   = (state != IDLE) || !tx_empty;

endmodule
